// File: rtl/cpu15_pkg.sv
// -----------------------------------------------------------------------------
// cpu15_pkg
// Shared definitions for the 15-bit CPU pipeline: opcode constants, the
// instruction-phase state encoding used by the sequencer, and the bit
// positions of the instruction fields inside PROM_OUT. Decode and execute
// stages import this package as well.
// -----------------------------------------------------------------------------
package cpu15_pkg;

  // Opcodes, PROM_OUT[14:11]
  localparam logic [3:0] OPC_ADD = 4'b0001;
  localparam logic [3:0] OPC_LDL = 4'b1000;
  localparam logic [3:0] OPC_LDH = 4'b1001;
  localparam logic [3:0] OPC_CMP = 4'b1010;
  localparam logic [3:0] OPC_JE  = 4'b1011;
  localparam logic [3:0] OPC_JMP = 4'b1100;
  localparam logic [3:0] OPC_ST  = 4'b1110;
  localparam logic [3:0] OPC_HLT = 4'b1111;

  // Instruction field positions inside PROM_OUT
  localparam int INSTR_WIDTH = 15;
  localparam int OPC_MSB     = 14;
  localparam int OPC_LSB     = 11;
  localparam int DATA_MSB    = 7;
  localparam int DATA_LSB    = 0;

  // Sequencer phase states
  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_FT   = 3'd1,
    PH_DC   = 3'd2,
    PH_EX   = 3'd3,
    PH_WB   = 3'd4,
    PH_HALT = 3'd5
  } phase_t;

endpackage

// File: rtl/pc_sequencer_next_pc.sv
// -----------------------------------------------------------------------------
// pc_sequencer_next_pc
// Combinational next-PC resolution for the instruction retiring in WB.
// Ports:
//   opcode  : latched opcode of the current instruction
//   target  : latched branch target (OP_DATA)
//   flag    : equal flag from the execute stage
//   pc      : current program counter
//   pc_next : program counter for the following instruction
//   halt    : 1 when the instruction is hlt
// -----------------------------------------------------------------------------
module pc_sequencer_next_pc
  import cpu15_pkg::*;
#(
  parameter int PC_WIDTH = 8
) (
  input  logic [3:0]          opcode,
  input  logic [PC_WIDTH-1:0] target,
  input  logic                flag,
  input  logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_next,
  output logic                halt
);

  logic [PC_WIDTH-1:0] pc_inc;

  // Sequential flow wraps naturally at 2^PC_WIDTH.
  assign pc_inc = pc + PC_WIDTH'(1);

  always_comb begin
    pc_next = pc_inc;
    halt    = 1'b0;
    case (opcode)
      OPC_JMP: pc_next = target;
      OPC_JE:  pc_next = flag ? target : pc_inc;
      OPC_HLT: begin
        pc_next = pc;
        halt    = 1'b1;
      end
      default: pc_next = pc_inc;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Program counter and instruction-phase sequencer feeding the fetch stage.
// Each instruction walks FT -> DC -> EX -> WB, one cycle per phase, with a
// registered one-hot enable per phase. The next PC is resolved at the end of
// WB from the opcode/operand latched at the end of DC and the equal flag.
// Ports:
//   CLK      : system clock, all state changes on posedge
//   RESET    : synchronous active-high reset
//   RUN      : permit starting a new instruction (sampled in IDLE and WB)
//   OP_CODE  : PROM_OUT[14:11] of the fetched instruction
//   OP_DATA  : PROM_OUT[7:0], branch target for jmp/je
//   CMP_FLAG : equal flag from execute, sampled during WB
//   P_COUNT  : current instruction address
//   EN_FT/EN_DC/EN_EX/EN_WB : one-hot phase enables
//   HALTED   : set once hlt has retired
// -----------------------------------------------------------------------------
module pc_sequencer
  import cpu15_pkg::*;
#(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RUN,
  input  logic [3:0]          OP_CODE,
  input  logic [7:0]          OP_DATA,
  input  logic                CMP_FLAG,
  output logic [PC_WIDTH-1:0] P_COUNT,
  output logic                EN_FT,
  output logic                EN_DC,
  output logic                EN_EX,
  output logic                EN_WB,
  output logic                HALTED
);

  phase_t              state_reg;
  phase_t              state_next;
  logic [PC_WIDTH-1:0] pc_reg;
  logic [3:0]          opc_reg;
  logic [7:0]          data_reg;
  logic                halted_reg;
  logic                en_ft_reg;
  logic                en_dc_reg;
  logic                en_ex_reg;
  logic                en_wb_reg;

  logic [PC_WIDTH-1:0] target;
  logic [PC_WIDTH-1:0] pc_next;
  logic                halt;

  // The operand field is 8 bits; fit it to the PC width.
  assign target = PC_WIDTH'(data_reg);

  pc_sequencer_next_pc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_next_pc (
    .opcode  (opc_reg),
    .target  (target),
    .flag    (CMP_FLAG),
    .pc      (pc_reg),
    .pc_next (pc_next),
    .halt    (halt)
  );

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PH_IDLE: state_next = RUN ? PH_FT : PH_IDLE;
      PH_FT:   state_next = PH_DC;
      PH_DC:   state_next = PH_EX;
      PH_EX:   state_next = PH_WB;
      PH_WB: begin
        if (halt)     state_next = PH_HALT;
        else if (RUN) state_next = PH_FT;
        else          state_next = PH_IDLE;
      end
      PH_HALT: state_next = PH_HALT;
      default: state_next = PH_IDLE;
    endcase
  end

  // State, PC and operand registers. Enables are registered from state_next
  // so they line up exactly with the state they announce.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg  <= PH_IDLE;
      pc_reg     <= RESET_PC;
      opc_reg    <= '0;
      data_reg   <= '0;
      halted_reg <= 1'b0;
      en_ft_reg  <= 1'b0;
      en_dc_reg  <= 1'b0;
      en_ex_reg  <= 1'b0;
      en_wb_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      en_ft_reg <= (state_next == PH_FT);
      en_dc_reg <= (state_next == PH_DC);
      en_ex_reg <= (state_next == PH_EX);
      en_wb_reg <= (state_next == PH_WB);

      // PROM_OUT is valid from the cycle after fetch; capture it as DC ends
      // so later input changes cannot disturb this instruction.
      if (state_reg == PH_DC) begin
        opc_reg  <= OP_CODE;
        data_reg <= OP_DATA;
      end

      if (state_reg == PH_WB) begin
        pc_reg <= pc_next;
        if (halt) begin
          halted_reg <= 1'b1;
        end
      end
    end
  end

  assign P_COUNT = pc_reg;
  assign EN_FT   = en_ft_reg;
  assign EN_DC   = en_dc_reg;
  assign EN_EX   = en_ex_reg;
  assign EN_WB   = en_wb_reg;
  assign HALTED  = halted_reg;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Driver issues instructions and pushes the expected address of the next
// fetch into a queue; a monitor pops it whenever the DUT raises EN_FT and
// also checks phase ordering and PC stability through each instruction.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;
  import cpu15_pkg::*;

  logic       CLK      = 1'b0;
  logic       RESET    = 1'b1;
  logic       RUN      = 1'b0;
  logic [3:0] OP_CODE  = 4'h0;
  logic [7:0] OP_DATA  = 8'h00;
  logic       CMP_FLAG = 1'b0;
  logic [7:0] P_COUNT;
  logic       EN_FT, EN_DC, EN_EX, EN_WB, HALTED;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic [7:0] pc_model  = 8'h00;
  logic [7:0] fetch_exp = 8'h00;
  logic [7:0] mon_e;
  logic       prev_ft = 1'b0, prev_dc = 1'b0, prev_ex = 1'b0;

  always #5 CLK = ~CLK;

  pc_sequencer #(
    .PC_WIDTH (8),
    .RESET_PC (8'h00)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .RUN      (RUN),
    .OP_CODE  (OP_CODE),
    .OP_DATA  (OP_DATA),
    .CMP_FLAG (CMP_FLAG),
    .P_COUNT  (P_COUNT),
    .EN_FT    (EN_FT),
    .EN_DC    (EN_DC),
    .EN_EX    (EN_EX),
    .EN_WB    (EN_WB),
    .HALTED   (HALTED)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (RESET) begin
      prev_ft <= 1'b0;
      prev_dc <= 1'b0;
      prev_ex <= 1'b0;
    end else begin
      check("phase_onehot", 32'($countones({EN_FT, EN_DC, EN_EX, EN_WB}) <= 1), 32'd1);
      if (EN_FT) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_fetch: P_COUNT %02h fetched, no fetch expected", P_COUNT);
        end else begin
          mon_e = exp_q.pop_front();
          check("fetch_pc", 32'(P_COUNT), 32'(mon_e));
          fetch_exp <= mon_e;
        end
      end
      if (EN_DC) begin
        check("dc_after_ft", 32'(prev_ft), 32'd1);
        check("pc_stable_dc", 32'(P_COUNT), 32'(fetch_exp));
      end
      if (EN_EX) begin
        check("ex_after_dc", 32'(prev_dc), 32'd1);
        check("pc_stable_ex", 32'(P_COUNT), 32'(fetch_exp));
      end
      if (EN_WB) begin
        check("wb_after_ex", 32'(prev_ex), 32'd1);
        check("pc_stable_wb", 32'(P_COUNT), 32'(fetch_exp));
      end
      if (EN_FT | EN_DC | EN_EX | EN_WB)
        check("not_halted_while_active", 32'(HALTED), 32'd0);
      prev_ft <= EN_FT;
      prev_dc <= EN_DC;
      prev_ex <= EN_EX;
    end
  end

  // ---------------- driver ----------------
  task automatic wait_ft(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (EN_FT) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: EN_FT not seen in 20 cycles, got none expected fetch at %02h", pc_model);
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input logic [7:0] data,
                           input logic flag, input logic run_after);
    bit         ok;
    bit         is_halt;
    logic [7:0] nxt;
    wait_ft(ok);
    if (!ok) return;
    // FT: present the instruction; RUN must not matter from here on
    OP_CODE  = op;
    OP_DATA  = data;
    RUN      = 1'($urandom);
    CMP_FLAG = 1'($urandom);
    @(negedge CLK);  // DC
    CMP_FLAG = 1'($urandom);
    @(negedge CLK);  // EX: operands already captured, scramble inputs
    OP_CODE  = 4'($urandom);
    OP_DATA  = 8'($urandom);
    CMP_FLAG = ~flag;
    @(negedge CLK);  // WB
    CMP_FLAG = flag;
    RUN      = run_after;
    is_halt  = 1'b0;
    if (op == OPC_JMP)      nxt = data;
    else if (op == OPC_JE)  nxt = flag ? data : pc_model + 8'd1;
    else if (op == OPC_HLT) begin
      nxt     = pc_model;
      is_halt = 1'b1;
    end else                nxt = pc_model + 8'd1;
    $display("instr pc=%02h op=%h data=%02h flag=%b run=%b -> next=%02h%s",
             pc_model, op, data, flag, run_after, nxt, is_halt ? " (halt)" : "");
    pc_model = nxt;
    if (!is_halt) exp_q.push_back(nxt);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_en"}, 32'({EN_FT, EN_DC, EN_EX, EN_WB}), 32'd0);
    check({tag, "_pc"}, 32'(P_COUNT), 32'h00);
    check({tag, "_halted"}, 32'(HALTED), 32'd0);
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    RUN   = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    check_reset_state("reset");
    exp_q.delete();
    pc_model = 8'h00;
    exp_q.push_back(8'h00);
    RESET = 1'b0;
    $display("reset applied, expecting fetch at 00");
  endtask

  task automatic check_halt();
    RUN = 1'b1;
    repeat (22) begin
      @(negedge CLK);
      check("halt_no_phase", 32'({EN_FT, EN_DC, EN_EX, EN_WB}), 32'd0);
      check("halt_pc", 32'(P_COUNT), 32'(pc_model));
      check("halted", 32'(HALTED), 32'd1);
    end
    $display("halt held 22 cycles at pc=%02h", pc_model);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("idle_no_phase", 32'({EN_FT, EN_DC, EN_EX, EN_WB}), 32'd0);
    end
    $display("idle %0d cycles at pc=%02h", n, pc_model);
    RUN = 1'b1;
  endtask

  task automatic abort_in_ex();
    bit ok;
    wait_ft(ok);
    if (!ok) return;
    OP_CODE = OPC_JMP;
    OP_DATA = 8'h55;
    @(negedge CLK);  // DC
    @(negedge CLK);  // EX
    RESET = 1'b1;
    RUN   = 1'b0;
    @(negedge CLK);
    check_reset_state("abort");
    exp_q.delete();
    pc_model = 8'h00;
    exp_q.push_back(8'h00);
    RESET = 1'b0;
    RUN   = 1'b1;
    $display("reset during EX, expecting fetch at 00");
  endtask

  initial begin
    int         r;
    logic [3:0] op;
    logic       ra;
    repeat (3) @(negedge CLK);
    do_reset();
    RUN = 1'b1;
    // sequential flow
    repeat (3) run_instr(OPC_ADD, 8'($urandom), 1'($urandom), 1'b1);
    // jmp
    run_instr(OPC_JMP, 8'h0d, 1'b0, 1'b1);
    run_instr(OPC_JMP, 8'h08, 1'b1, 1'b1);
    // je not taken / taken
    run_instr(OPC_JMP, 8'h0c, 1'b0, 1'b1);
    run_instr(OPC_JE,  8'h0e, 1'b0, 1'b1);
    run_instr(OPC_JMP, 8'h0c, 1'b0, 1'b1);
    run_instr(OPC_JE,  8'h0e, 1'b1, 1'b1);
    // hlt at 0e
    run_instr(OPC_HLT, 8'h33, 1'b0, 1'b1);
    check_halt();
    do_reset();
    RUN = 1'b1;
    // wrap at FF with RUN dropped in WB
    run_instr(OPC_JMP, 8'hff, 1'b0, 1'b1);
    run_instr(OPC_ADD, 8'h12, 1'b0, 1'b0);
    idle_gap(10);
    run_instr(OPC_ADD, 8'h00, 1'b0, 1'b1);
    // randomized traffic
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      op = OPC_JMP;
      else if (r < 6) op = OPC_JE;
      else            op = 4'($urandom_range(0, 14));
      ra = ($urandom_range(0, 4) != 0);
      run_instr(op, 8'($urandom), 1'($urandom), ra);
      if (!ra) idle_gap($urandom_range(1, 5));
    end
    // reset in the middle of an instruction
    run_instr(OPC_JMP, 8'h40, 1'b0, 1'b1);
    abort_in_ex();
    run_instr(OPC_ADD, 8'h00, 1'b0, 1'b1);
    run_instr(OPC_ADD, 8'h00, 1'b0, 1'b1);
    run_instr(OPC_HLT, 8'h00, 1'b0, 1'b1);
    check_halt();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

endmodule
